// File: rtl/bar_frame_sequencer.sv
// bar_frame_sequencer: loads NUM_BARS bar heights from the bar RAM into a
// shadow bank after each rising edge of data_back, then copies the shadow into
// the display bank on the next frame_sync, so the display never shows a
// partially loaded spectrum.
// Optional build macro: BAR_PEAK_DECAY_EN (peak hold, display falls by 1 per swap).
module bar_frame_sequencer #(
    parameter int NUM_BARS   = 20,
    parameter int HEIGHT_W   = 6,
    parameter int ADDR_W     = 6,
    parameter int RD_LATENCY = 2
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         data_back,
    input  logic                         frame_sync,
    input  logic [HEIGHT_W-1:0]          ram_q,
    output logic [ADDR_W-1:0]            ram_rdaddress,
    output logic [NUM_BARS*HEIGHT_W-1:0] height,
    output logic                         height_valid,
    output logic                         busy,
    output logic [7:0]                   overrun_cnt
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_FETCH     = 2'd1;
    localparam logic [1:0] ST_WAIT_SWAP = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BARS - 1);

    logic [1:0]                   state;
    logic [1:0]                   state_next;
    logic                         db_old;
    logic                         req;
    logic                         start_fetch;
    logic                         do_swap;
    logic                         drop_req;
    logic                         issuing;
    logic                         last_capture;
    logic [RD_LATENCY-1:0]        pipe_vld;
    logic [ADDR_W-1:0]            pipe_idx [RD_LATENCY];
    logic [HEIGHT_W-1:0]          shadow   [NUM_BARS];
    logic [NUM_BARS*HEIGHT_W-1:0] swap_value;
`ifdef BAR_PEAK_DECAY_EN
    logic [HEIGHT_W-1:0]          cur_h;
    logic [HEIGHT_W-1:0]          dec_h;
`endif

    assign req          = data_back & ~db_old;
    assign last_capture = pipe_vld[RD_LATENCY-1] && (pipe_idx[RD_LATENCY-1] == LAST_ADDR);

    // Next-state decode; a request coinciding with the swap is accepted, not dropped
    always_comb begin
        state_next  = state;
        start_fetch = 1'b0;
        do_swap     = 1'b0;
        drop_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_next  = ST_FETCH;
                    start_fetch = 1'b1;
                end
            end
            ST_FETCH: begin
                if (last_capture) state_next = ST_WAIT_SWAP;
                if (req) drop_req = 1'b1;
            end
            ST_WAIT_SWAP: begin
                if (frame_sync) begin
                    do_swap = 1'b1;
                    if (req) begin
                        state_next  = ST_FETCH;
                        start_fetch = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (req) begin
                    drop_req = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register, registered busy decode, edge-detect history, overrun counter
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            db_old      <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            state  <= state_next;
            busy   <= (state_next != ST_IDLE);
            db_old <= data_back;
            if (drop_req && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    // Address issue: one address per cycle 0..NUM_BARS-1, then hold the last one
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            issuing       <= 1'b0;
            ram_rdaddress <= '0;
        end else if (start_fetch) begin
            issuing       <= 1'b1;
            ram_rdaddress <= '0;
        end else if (issuing) begin
            if (ram_rdaddress == LAST_ADDR) issuing <= 1'b0;
            else ram_rdaddress <= ram_rdaddress + ADDR_W'(1);
        end else if (do_swap) begin
            ram_rdaddress <= '0;
        end
    end

    // Valid/index pipeline matching the RAM read latency
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int j = 0; j < RD_LATENCY; j++) pipe_idx[j] <= '0;
        end else begin
            pipe_vld[0] <= issuing;
            pipe_idx[0] <= ram_rdaddress;
            for (int j = 1; j < RD_LATENCY; j++) begin
                pipe_vld[j] <= pipe_vld[j-1];
                pipe_idx[j] <= pipe_idx[j-1];
            end
        end
    end

    // Capture returning RAM data into the shadow slot named by the pipeline
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_BARS; k++) shadow[k] <= '0;
        end else if (pipe_vld[RD_LATENCY-1]) begin
            for (int k = 0; k < NUM_BARS; k++) begin
                if (pipe_idx[RD_LATENCY-1] == ADDR_W'(k)) shadow[k] <= ram_q;
            end
        end
    end

    // Value written into the display bank at the swap
    always_comb begin
        swap_value = '0;
`ifdef BAR_PEAK_DECAY_EN
        cur_h = '0;
        dec_h = '0;
        for (int k = 0; k < NUM_BARS; k++) begin
            cur_h = height[k*HEIGHT_W +: HEIGHT_W];
            dec_h = (cur_h == '0) ? '0 : (cur_h - HEIGHT_W'(1));
            swap_value[k*HEIGHT_W +: HEIGHT_W] = (shadow[k] > dec_h) ? shadow[k] : dec_h;
        end
`else
        for (int k = 0; k < NUM_BARS; k++) begin
            swap_value[k*HEIGHT_W +: HEIGHT_W] = shadow[k];
        end
`endif
    end

    // Display bank: changes only at the swap edge
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            height       <= '0;
            height_valid <= 1'b0;
        end else if (do_swap) begin
            height       <= swap_value;
            height_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bar_frame_sequencer.sv
// Scoreboard bench for bar_frame_sequencer: stimulus pushes timestamped
// expectations computed from a frame-level model; a monitor compares them.
// Honours BAR_PEAK_DECAY_EN in its model when the macro is defined.
module tb_bar_frame_sequencer;

    localparam int NUM_BARS   = 20;
    localparam int HEIGHT_W   = 6;
    localparam int ADDR_W     = 6;
    localparam int RD_LATENCY = 2;
    localparam int HW         = NUM_BARS * HEIGHT_W;
    localparam int LOAD_CYC   = NUM_BARS + RD_LATENCY;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                data_back = 1'b0;
    logic                frame_sync = 1'b0;
    logic [HEIGHT_W-1:0] ram_q;
    logic [ADDR_W-1:0]   ram_rdaddress;
    logic [HW-1:0]       height;
    logic                height_valid;
    logic                busy;
    logic [7:0]          overrun_cnt;

    always #5 clk = ~clk;

    bar_frame_sequencer #(
        .NUM_BARS  (NUM_BARS),
        .HEIGHT_W  (HEIGHT_W),
        .ADDR_W    (ADDR_W),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (rst),
        .data_back    (data_back),
        .frame_sync   (frame_sync),
        .ram_q        (ram_q),
        .ram_rdaddress(ram_rdaddress),
        .height       (height),
        .height_valid (height_valid),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt)
    );

    // Bar RAM: data appears RD_LATENCY edges after the address
    logic [HEIGHT_W-1:0] mem     [2**ADDR_W];
    logic [ADDR_W-1:0]   rd_pipe [RD_LATENCY];
    always @(posedge clk) begin
        rd_pipe[0] <= ram_rdaddress;
        for (int j = 1; j < RD_LATENCY; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign ram_q = mem[rd_pipe[RD_LATENCY-1]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                at;
        logic [HW-1:0]     height;
        logic              hv;
        logic              busy;
        logic [7:0]        ovr;
        logic [ADDR_W-1:0] addr;
        bit                chk_addr;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Frame-level model of what the display should show
    int   exp_disp [NUM_BARS];
    logic exp_hv;
    int   exp_ovr;

    function automatic logic [HW-1:0] model_height();
        logic [HW-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_BARS; k++) v[k*HEIGHT_W +: HEIGHT_W] = HEIGHT_W'(exp_disp[k]);
        return v;
    endfunction

    function automatic void push(string nm, int at, logic b, int a, bit ca);
        exp_t r;
        r.at       = at;
        r.height   = model_height();
        r.hv       = exp_hv;
        r.busy     = b;
        r.ovr      = 8'(exp_ovr);
        r.addr     = ADDR_W'(a);
        r.chk_addr = ca;
        exp_q.push_back(r);
        name_q.push_back(nm);
    endfunction

    task automatic check(string nm, string fld, logic [HW-1:0] act, logic [HW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s at cycle %0d: got %h, expected %h", nm, fld, cyc, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against every expectation due this cycle
    initial begin : monitor
        exp_t  cur;
        string cur_nm;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                cur    = exp_q.pop_front();
                cur_nm = name_q.pop_front();
                check(cur_nm, "height", height, cur.height);
                check(cur_nm, "height_valid", HW'(height_valid), HW'(cur.hv));
                check(cur_nm, "busy", HW'(busy), HW'(cur.busy));
                check(cur_nm, "overrun_cnt", HW'(overrun_cnt), HW'(cur.ovr));
                if (cur.chk_addr) check(cur_nm, "ram_rdaddress", HW'(ram_rdaddress), HW'(cur.addr));
            end
        end
    end

    initial begin : watchdog
        repeat (50000) @(posedge clk);
        n_bad++;
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    function automatic void model_swap(input logic [HEIGHT_W-1:0] loaded [NUM_BARS]);
        int dec;
        for (int k = 0; k < NUM_BARS; k++) begin
`ifdef BAR_PEAK_DECAY_EN
            dec = (exp_disp[k] > 0) ? exp_disp[k] - 1 : 0;
            exp_disp[k] = (int'(loaded[k]) > dec) ? int'(loaded[k]) : dec;
`else
            exp_disp[k] = int'(loaded[k]);
`endif
        end
        exp_hv = 1'b1;
    endfunction

    function automatic void bump_ovr();
        exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
    endfunction

    function automatic bit is_rise(int x, int t, int w, int s, int ovr_f, int n_w, bit co);
        return (ovr_f != 0 && x == t + ovr_f) ||
               (n_w > 0 && x >= w + 2 && x <= w + 2 * n_w && ((x - w) % 2 == 0)) ||
               (co && x == s);
    endfunction

    task automatic randomize_mem();
        for (int a = 0; a < NUM_BARS; a++) mem[a] = HEIGHT_W'($urandom);
    endtask

    // Idle cycles with stray frame_sync pulses, which must be ignored
    task automatic idle(int n, logic hold);
        for (int i = 0; i < n; i++) begin
            data_back  = hold;
            frame_sync = ($urandom_range(0, 3) == 0);
            push("idle", cyc + 1, 1'b0, 0, 1'b1);
            @(negedge clk);
        end
        frame_sync = 1'b0;
    endtask

    // One load: request at edge t (or already accepted at t when chained),
    // ovr_f = fetch-time rising edge offset, n_w = rising edges during WAIT_SWAP,
    // swap gap cycles after WAIT_SWAP entry, optional request coincident with swap.
    task automatic load(int gap, int ovr_f, int n_w, bit chained, bit coincide);
        int t, w, s, c, e, a;
        logic [HEIGHT_W-1:0] loaded [NUM_BARS];
        for (int k = 0; k < NUM_BARS; k++) loaded[k] = mem[k];
        c = cyc;
        t = chained ? c : c + 1;
        w = t + LOAD_CYC;
        s = w + gap;
        while (c < s) begin
            e = c + 1;
            data_back  = (e >= t) && !is_rise(e + 1, t, w, s, ovr_f, n_w, coincide);
            frame_sync = (e == s) || (gap >= 2 && (e == w || e == t + 5));
            a = (e - t < NUM_BARS) ? e - t : NUM_BARS - 1;
            if (ovr_f != 0 && e == t + ovr_f) bump_ovr();
            if (is_rise(e, t, w, s, 0, n_w, 1'b0)) bump_ovr();
            if (e == s) model_swap(loaded);
            if (!chained && e == t) push("fetch_start", e, 1'b1, 0, 1'b1);
            if (ovr_f != 0 && e == t + ovr_f) push("ovr_fetch", e, 1'b1, a, 1'b1);
            if (is_rise(e, t, w, s, 0, n_w, 1'b0)) push("ovr_wait", e, 1'b1, NUM_BARS - 1, 1'b1);
            if (e == t + NUM_BARS / 2) push("mid_fetch", e, 1'b1, NUM_BARS / 2, 1'b1);
            if (e == w) push("wait_entry", e, 1'b1, NUM_BARS - 1, 1'b1);
            if (e == s - 1 && e != w) push("pre_swap", e, 1'b1, NUM_BARS - 1, 1'b1);
            if (e == s) push(coincide ? "swap_accept" : "swap", e, coincide, 0, 1'b1);
            @(negedge clk);
            c++;
        end
        frame_sync = 1'b0;
    endtask

    task automatic reset_mid_fetch();
        int t;
        idle(2, 1'b0);
        randomize_mem();
        mem[0]    = '0;
        data_back = 1'b1;
        t = cyc + 1;
        push("rst_fetch_start", t, 1'b1, 0, 1'b1);
        repeat (6) @(negedge clk);
        push("pre_reset", t + 6, 1'b1, 6, 1'b1);
        @(negedge clk);
        for (int k = 0; k < NUM_BARS; k++) exp_disp[k] = 0;
        exp_hv  = 1'b0;
        exp_ovr = 0;
        push("reset_async", t + 7, 1'b0, 0, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        data_back = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(2, 1'b0);
        load(3, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin : stimulus
        int gap, ovr_f, n_w;
        int peaks [4];
        peaks[0] = 40; peaks[1] = 10; peaks[2] = 10; peaks[3] = 63;
        for (int a = 0; a < 2**ADDR_W; a++) mem[a] = '0;
        for (int k = 0; k < NUM_BARS; k++) exp_disp[k] = 0;
        exp_hv  = 1'b0;
        exp_ovr = 0;
        push("reset_state", 2, 1'b0, 0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(3, 1'b0);

        // Directed load with q = addr + 3
        for (int a = 0; a < NUM_BARS; a++) mem[a] = HEIGHT_W'(a + 3);
        load(5, 0, 0, 1'b0, 1'b0);
        // Level held high: no further loads, no overruns
        idle(100, 1'b1);
        idle(2, 1'b0);

        // One dropped request in FETCH, one in WAIT_SWAP
        randomize_mem();
        load(6, 10, 1, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Request coincident with the swap starts the next load at once
        randomize_mem();
        load(4, 0, 0, 1'b0, 1'b1);
        randomize_mem();
        load(2, 0, 0, 1'b1, 1'b0);

        // Randomized loads
        for (int i = 0; i < 6; i++) begin
            idle($urandom_range(1, 4), 1'b0);
            randomize_mem();
            gap   = $urandom_range(1, 8);
            ovr_f = ($urandom_range(0, 1) == 1) ? $urandom_range(2, LOAD_CYC - 2) : 0;
            n_w   = (gap >= 4 && $urandom_range(0, 1) == 1) ? $urandom_range(1, (gap - 2) / 2) : 0;
            load(gap, ovr_f, n_w, 1'b0, 1'b0);
        end

        // Overrun counter saturation
        idle(2, 1'b0);
        randomize_mem();
        load(545, 0, 270, 1'b0, 1'b0);

        reset_mid_fetch();

        // Peak sequence on bar 0 (decay build: 40, 39, 38, 63)
        for (int i = 0; i < 4; i++) begin
            idle(2, 1'b0);
            randomize_mem();
            mem[0] = HEIGHT_W'(peaks[i]);
            load(3, 0, 0, 1'b0, 1'b0);
        end

        idle(4, 1'b0);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bar_frame_sequencer.md
# bar_frame_sequencer

Sequences the per-frame read of bar heights from the dual-port bar RAM into a shadow register bank, then swaps the shadow into the display bank on a VGA frame boundary. The display never shows a partially loaded spectrum. Sits between the Nios II PIO handshake (`data_back`), the bar RAM read port, and the VGA controller's `height` input. It replaces the ad-hoc counter/case loader in the top level.

## Interface
Parameters:
- `NUM_BARS`, 20: number of bars, at RAM addresses 0..NUM_BARS-1.
- `HEIGHT_W`, 6: bar height width.
- `ADDR_W`, 6: RAM read-address width; requires NUM_BARS ≤ 2^ADDR_W.
- `RD_LATENCY`, 2: cycles from address presented to `ram_q` valid; must be ≥1.

Ports:
- `CLOCK_50` in 1: sole clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `data_back` in 1: Nios "frame written" level; a rising edge requests a load.
- `frame_sync` in 1: one-cycle pulse at VGA vertical-blank start, synchronous to `CLOCK_50`.
- `ram_q` in HEIGHT_W: bar RAM read data.
- `ram_rdaddress` out ADDR_W: bar RAM read address.
- `height` out NUM_BARS*HEIGHT_W: display bank, bar i at bits [i*HEIGHT_W +: HEIGHT_W].
- `height_valid` out 1: high once the first swap has completed.
- `busy` out 1: high in FETCH or WAIT_SWAP.
- `overrun_cnt` out 8: count of dropped load requests, saturating.

## Operation
- Edge detect: `data_back` is registered into `db_old`, reset 0. `req = data_back & ~db_old`.
- FSM states: IDLE, FETCH, WAIT_SWAP. Reset state is IDLE.
- **IDLE:**
  - `ram_rdaddress` = 0.
  - On `req`: go to FETCH, clear the issue and capture counters.
- **FETCH:**
  - Issue addresses 0..NUM_BARS-1, one per cycle.
  - A RD_LATENCY-deep valid/index pipeline captures `ram_q` into `shadow[k]`.
  - After the last issue, `ram_rdaddress` holds NUM_BARS-1.
  - When `shadow[NUM_BARS-1]` is captured, go to WAIT_SWAP.
- **WAIT_SWAP:**
  - `frame_sync` is sampled only in this state; it is ignored elsewhere.
  - On `frame_sync`: display ← shadow (all bars in one cycle), `height_valid` ← 1, then go to IDLE.
- **Overrun:**
  - A `req` in FETCH or WAIT_SWAP is dropped, `overrun_cnt` += 1, saturating at 255.
  - Exception: if `req` and `frame_sync` coincide in WAIT_SWAP, the swap happens, the request is accepted, and the next state is FETCH (not counted).
- `busy` is a registered decode of the state: 1 in FETCH/WAIT_SWAP.
- Reset mid-operation (any state): immediately returns to IDLE. Shadow, display, counters, `height_valid`, `overrun_cnt` and `db_old` all go to 0.
- Reset values: `ram_rdaddress`=0, `height`=0, `height_valid`=0, `busy`=0, `overrun_cnt`=0.

## Timing
- `req` is seen at edge t, i.e. `data_back` is high and `db_old` is low at t.
- Edge t+1: state = FETCH, `ram_rdaddress` = 0, `busy` = 1.
- Address i is driven during cycle t+1+i.
- `ram_q` for bar i is captured at edge t+1+i+RD_LATENCY.
- The last capture is at t+NUM_BARS+RD_LATENCY; WAIT_SWAP follows on the next cycle.
- Default parameters: the load takes 22 cycles from `req` to WAIT_SWAP entry.
- `frame_sync` sampled at edge s in WAIT_SWAP: `height` updates at s; IDLE and `busy`=0 from s.
- Earliest next accepted `req` is the swap cycle itself.
- `height` is stable except at the swap edge. It never changes during FETCH.

## Configuration
- `BAR_PEAK_DECAY_EN` defined:
  - At swap, each bar gets display[i] ← max(shadow[i], display[i] − 1).
  - Subtraction saturates at 0, width HEIGHT_W, unsigned compare.
  - Effect: peak hold with a fall of 1 per frame.
- Undefined: display[i] ← shadow[i] exactly.

## Test plan
- RAM model q = addr+3. Pulse `data_back` 0→1, then `frame_sync` 5 cycles after WAIT_SWAP entry → WAIT_SWAP entry 22 cycles after `req`; bar i = i+3 (bar 19 = 22); `height_valid`=1; `busy`=0.
- Hold `data_back` high for 100 cycles → exactly one load; `overrun_cnt` stays 0.
- Second rising edge at FETCH cycle 10, third during WAIT_SWAP → `overrun_cnt`=2; `height` is unchanged until `frame_sync`.
- Rising edge of `data_back` coincident with `frame_sync` in WAIT_SWAP → swap occurs, next state FETCH, `ram_rdaddress`=0 on the following edge, `overrun_cnt` unchanged.
- Assert `reset` at FETCH cycle 7 → all outputs 0 asynchronously; after release a new `req` performs a full 20-bar load.
- With `BAR_PEAK_DECAY_EN`: display bar 0 = 40, RAM bar 0 = 10; swap → 39; second swap → 38. With RAM bar 0 = 63 → 63. With display 0 and RAM 0 → 0 (no wrap).
